// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : midi_pkg
// Description : Shared constants and types for the MIDI message parser:
//               event type codes, channel status nibbles, system byte codes
//               and the parser state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

    // Event type codes presented on evt_type
    localparam logic [1:0] EVT_NOTE_ON  = 2'd1;
    localparam logic [1:0] EVT_NOTE_OFF = 2'd2;
    localparam logic [1:0] EVT_CC       = 2'd3;

    // Upper nibble of channel-voice status bytes
    localparam logic [3:0] STAT_NOTE_OFF = 4'h8;
    localparam logic [3:0] STAT_NOTE_ON  = 4'h9;
    localparam logic [3:0] STAT_POLY_AT  = 4'hA;
    localparam logic [3:0] STAT_CC       = 4'hB;
    localparam logic [3:0] STAT_PROG     = 4'hC;
    localparam logic [3:0] STAT_CHAN_AT  = 4'hD;
    localparam logic [3:0] STAT_PITCH    = 4'hE;

    // System byte codes
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    // Realtime bytes may appear anywhere and never disturb parsing.
    function automatic logic is_realtime(input logic [7:0] b);
        return (b >= RT_MIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : midi_skid_reg
// Description : One-entry skid buffer that catches the byte the FIFO may
//               still send after rdy2rcv falls (the FIFO sees rdy2rcv one
//               cycle late).
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               push/push_data - store a byte
//               pop            - consume the stored byte
//               data/full      - stored byte and occupancy
//               ovf            - sticky: a byte arrived while full (dropped)
// Revision    : 1.0 - initial release
// ============================================================================
module midi_skid_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] data,
    output logic       full,
    output logic       ovf
);

    logic [7:0] r_data;
    logic       r_full;
    logic       r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            // A pop frees the slot in the same cycle, so push+pop refills it.
            if (push && (!r_full || pop)) begin
                r_data <= push_data;
                r_full <= 1'b1;
            end else if (pop) begin
                r_full <= 1'b0;
            end
            if (push && r_full && !pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign data = r_data;
    assign full = r_full;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// Module      : midi_msg_parser
// Description : Assembles MIDI channel-voice messages from the FIFO byte
//               stream and emits note-on/note-off events (plus control
//               change when MIDI_CC_EN is defined) over valid/ready.
//               Supports running status, realtime bytes and SysEx skipping.
// Config      : `define MIDI_CC_EN to emit 0xBn messages as evt_type=3.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_data, in_d_rdy   - byte stream from FIFO
//               rdy2rcv             - backpressure to FIFO
//               evt_valid, evt_rdy  - event handshake
//               evt_type/chan/key/val - event payload
// Revision    : 1.0 - initial release
// ============================================================================
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int OMNI    = 1,
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_d_rdy,
    output logic       rdy2rcv,
    output logic       evt_valid,
    input  logic       evt_rdy,
    output logic [1:0] evt_type,
    output logic [3:0] evt_chan,
    output logic [6:0] evt_key,
    output logic [6:0] evt_val
);

    localparam logic [3:0] C_CHANNEL = CHANNEL[3:0];

    state_t     r_state,     w_state_nxt;
    logic [7:0] r_status,    w_status_nxt;
    logic [6:0] r_key,       w_key_nxt;
    logic       r_discard,   w_discard_nxt;
    logic       r_evt_valid, w_evt_valid_nxt;
    logic [1:0] r_evt_type,  w_evt_type_nxt;
    logic [3:0] r_evt_chan,  w_evt_chan_nxt;
    logic [6:0] r_evt_key,   w_evt_key_nxt;
    logic [6:0] r_evt_val,   w_evt_val_nxt;

    logic       w_skid_full;
    logic [7:0] w_skid_data;
    logic       w_skid_push;
    logic       w_skid_pop;
    logic       w_skid_ovf_unused;
    logic       w_proc;
    logic [7:0] w_byte;
    logic       w_chan_ok;

    // Bytes that cannot be processed this cycle (event pending, or an older
    // byte still waiting in the skid) are parked in the skid.
    assign w_skid_push = in_d_rdy && (r_evt_valid || w_skid_full);
    assign w_skid_pop  = !r_evt_valid && w_skid_full;
    assign w_proc      = !r_evt_valid && (w_skid_full || in_d_rdy);
    assign w_byte      = w_skid_full ? w_skid_data : in_data;
    assign w_chan_ok   = (OMNI != 0) || (r_status[3:0] == C_CHANNEL);

    midi_skid_reg u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_skid_push),
        .push_data (in_data),
        .pop       (w_skid_pop),
        .data      (w_skid_data),
        .full      (w_skid_full),
        .ovf       (w_skid_ovf_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_status    <= '0;
            r_key       <= '0;
            r_discard   <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_type  <= '0;
            r_evt_chan  <= '0;
            r_evt_key   <= '0;
            r_evt_val   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_status    <= w_status_nxt;
            r_key       <= w_key_nxt;
            r_discard   <= w_discard_nxt;
            r_evt_valid <= w_evt_valid_nxt;
            r_evt_type  <= w_evt_type_nxt;
            r_evt_chan  <= w_evt_chan_nxt;
            r_evt_key   <= w_evt_key_nxt;
            r_evt_val   <= w_evt_val_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_status_nxt    = r_status;
        w_key_nxt       = r_key;
        w_discard_nxt   = r_discard;
        w_evt_valid_nxt = r_evt_valid;
        w_evt_type_nxt  = r_evt_type;
        w_evt_chan_nxt  = r_evt_chan;
        w_evt_key_nxt   = r_evt_key;
        w_evt_val_nxt   = r_evt_val;

        if (r_evt_valid && evt_rdy) begin
            w_evt_valid_nxt = 1'b0;
        end

        // w_proc implies no event is pending, so it never collides with the
        // handshake clear above.
        if (w_proc && !is_realtime(w_byte)) begin
            if (w_byte[7] && (w_byte < SYSEX_START)) begin
                w_status_nxt  = w_byte;
                w_state_nxt   = WAIT_D1;
                w_key_nxt     = '0;
                w_discard_nxt = 1'b0;
            end else if (w_byte == SYSEX_START) begin
                w_status_nxt = '0;
                w_state_nxt  = SYSEX;
            end else if (w_byte inside {[8'hF1:SYSEX_END]}) begin
                w_status_nxt = '0;
                w_state_nxt  = IDLE;
            end else begin
                case (r_state)
                    WAIT_D1: begin
                        w_key_nxt = w_byte[6:0];
                        case (r_status[7:4])
                            STAT_NOTE_OFF, STAT_NOTE_ON: begin
                                w_state_nxt   = WAIT_D2;
                                w_discard_nxt = 1'b0;
                            end
`ifdef MIDI_CC_EN
                            STAT_CC: begin
                                w_state_nxt   = WAIT_D2;
                                w_discard_nxt = 1'b0;
                            end
                            STAT_POLY_AT, STAT_PITCH: begin
                                w_state_nxt   = WAIT_D2;
                                w_discard_nxt = 1'b1;
                            end
`else
                            // CC is still parsed as two bytes so running
                            // status stays aligned, but it is dropped.
                            STAT_CC, STAT_POLY_AT, STAT_PITCH: begin
                                w_state_nxt   = WAIT_D2;
                                w_discard_nxt = 1'b1;
                            end
`endif
                            STAT_PROG, STAT_CHAN_AT: begin
                                w_state_nxt = WAIT_D1;
                            end
                            default: begin
                                w_state_nxt = WAIT_D1;
                            end
                        endcase
                    end
                    WAIT_D2: begin
                        w_state_nxt = WAIT_D1;
                        if (!r_discard && w_chan_ok) begin
                            w_evt_valid_nxt = 1'b1;
                            w_evt_chan_nxt  = r_status[3:0];
                            w_evt_key_nxt   = r_key;
                            case (r_status[7:4])
                                STAT_NOTE_ON: begin
                                    // Velocity 0 is the running-status form
                                    // of note-off.
                                    if (w_byte[6:0] != 7'd0) begin
                                        w_evt_type_nxt = EVT_NOTE_ON;
                                        w_evt_val_nxt  = w_byte[6:0];
                                    end else begin
                                        w_evt_type_nxt = EVT_NOTE_OFF;
                                        w_evt_val_nxt  = 7'd0;
                                    end
                                end
                                STAT_NOTE_OFF: begin
                                    w_evt_type_nxt = EVT_NOTE_OFF;
                                    w_evt_val_nxt  = w_byte[6:0];
                                end
`ifdef MIDI_CC_EN
                                default: begin
                                    w_evt_type_nxt = EVT_CC;
                                    w_evt_val_nxt  = w_byte[6:0];
                                end
`else
                                default: begin
                                    w_evt_valid_nxt = 1'b0;
                                end
`endif
                            endcase
                        end
                    end
                    default: begin
                        // IDLE and SYSEX drop data bytes.
                    end
                endcase
            end
        end
    end

    assign rdy2rcv   = !(r_evt_valid || w_skid_full);
    assign evt_valid = r_evt_valid;
    assign evt_type  = r_evt_type;
    assign evt_chan  = r_evt_chan;
    assign evt_key   = r_evt_key;
    assign evt_val   = r_evt_val;

endmodule
`default_nettype wire

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Consumes the byte stream leaving the input byte FIFO (8-bit data plus a one-cycle `out_d_rdy` strobe) and assembles MIDI channel-voice messages.
- Emits decoded note-on/note-off (optionally control-change) events to the voice allocator through a valid/ready handshake.
- Drives `rdy2rcv` back to the FIFO to apply backpressure.
- Handles running status, realtime bytes and SysEx skipping.

Parameters:
- OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL.
- CHANNEL, 0, MIDI channel (0-15) accepted when OMNI=0.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  byte from FIFO, valid when in_d_rdy=1
- in_d_rdy  in  1  one-cycle byte strobe from FIFO
- rdy2rcv  out  1  parser can take bytes; FIFO samples it registered (one cycle late)
- evt_valid  out  1  event held on outputs until accepted
- evt_rdy  in  1  consumer accepts event when evt_valid & evt_rdy
- evt_type  out  2  1=note_on, 2=note_off, 3=control_change (only with MIDI_CC_EN)
- evt_chan  out  4  MIDI channel
- evt_key  out  7  note number / controller number
- evt_val  out  7  velocity / controller value

Behaviour:
- Reset (async, rst_n=0):
  - outputs: evt_valid=0, evt_type=0, evt_chan=0, evt_key=0, evt_val=0, rdy2rcv=1.
  - internal: state=IDLE, running status cleared, skid empty.
- Byte acceptance:
  - A byte is taken on every cycle with in_d_rdy=1, regardless of rdy2rcv.
  - Because the FIFO sees rdy2rcv one cycle late, one extra byte may arrive after rdy2rcv falls. It goes into a 1-byte skid register.
  - If the skid is full and another byte arrives, the byte is dropped and the sticky ovf flag is set (debug only). This is a protocol violation.
- rdy2rcv=0 while evt_valid=1 or the skid is occupied; otherwise 1.
- Processing order:
  - The skid byte is processed first, on the first cycle with evt_valid=0.
  - Otherwise a live byte is processed the cycle it arrives, if evt_valid=0.
  - At most one byte is processed per cycle.
- Byte classes:
  - 0xF8-0xFF realtime: discarded; state, running status and the partial message are untouched.
  - 0x80-0xEF channel status: store as running status, go to WAIT_D1, clear the partial message.
  - 0xF0: go to SYSEX, clear running status.
  - 0xF1-0xF7 (non-realtime system): clear running status, go to IDLE. 0xF7 also ends SYSEX.
  - Data byte (bit7=0): handled per state below.
- States:
  - IDLE: data bytes discarded.
  - WAIT_D1: latch key=byte[6:0].
    - If status is 0x8n/0x9n (or 0xBn with MIDI_CC_EN), go to WAIT_D2.
    - Other two-byte statuses (0xAn, 0xEn, and 0xBn without CC) go to WAIT_D2 with a discard flag set.
    - One-byte statuses (0xCn, 0xDn) return to WAIT_D1 with no event.
  - WAIT_D2: latch val=byte[6:0]. Emit the event unless discard is set, or OMNI=0 and the channel ≠ CHANNEL. Return to WAIT_D1 (running status).
  - SYSEX: data bytes discarded until any status byte. That status byte is handled normally (0xF7 → IDLE).
- Event decode:
  - 0x9n with val≠0 → note_on.
  - 0x9n with val=0 → note_off, val=0.
  - 0x8n → note_off, val = release velocity.
- Latency: evt_valid rises the cycle after the second data byte is processed. Outputs stay stable while evt_valid=1 & evt_rdy=0. evt_valid clears the cycle after the handshake.
- Simultaneous handshake and new byte: when evt_valid & evt_rdy and in_d_rdy occur in the same cycle, the byte goes to the skid (or is processed next cycle). No byte is lost.
- Reset mid-message: all partial state is discarded; the first byte after reset must be a status byte to produce events.

Optional Feature:
- MIDI_CC_EN defined:
  - 0xBn messages emit evt_type=3, evt_key=controller, evt_val=value.
  - Controller 123 (all notes off) also emits evt_type=3; the consumer interprets it.
- MIDI_CC_EN undefined:
  - 0xBn is parsed for running-status correctness but produces no event.
  - evt_type never equals 3.

Decomposition:
- Shared package midi_pkg holds:
  - event type codes EVT_NOTE_ON=1, EVT_NOTE_OFF=2, EVT_CC=3;
  - status nibble constants 0x8-0xE;
  - SYSEX_START=0xF0, SYSEX_END=0xF7, RT_MIN=0xF8;
  - the parser state enum (IDLE, WAIT_D1, WAIT_D2, SYSEX).
- Sub-module midi_skid_reg: the 1-entry skid buffer with full flag and overflow flag.
- Classification and the FSM stay in midi_msg_parser.

Test Plan:
- Bytes 0x90,0x3C,0x64 with evt_rdy=1 → one event: type=1, chan=0, key=60, val=100, one cycle after the last byte.
- Running status: 0x91,0x40,0x50,0x40,0x00 → note_on(chan 1,key 64,val 80), then note_off(chan 1,key 64,val 0).
- Realtime injection: 0x90,0xF8,0x3C,0xFE,0x64 → single note_on key 60 val 100; state undisturbed.
- Backpressure: hold evt_rdy=0 and send two complete messages back-to-back → rdy2rcv falls. The first event is held stable and the next byte lands in the skid. Releasing evt_rdy delivers both events in order, with ovf=0.
- SysEx: 0xF0,0x7E,0x01,0xF7,0x3C,0x64 → no events. Then 0x80,0x3C,0x20 → note_off key 60 val 32.
- Filter and reset: with OMNI=0, CHANNEL=2, send 0x93,0x3C,0x64 → no event, and 0x92,... → event. Assert rst_n=0 between 0x92 and 0x3C → no event afterwards; outputs return to reset values immediately.
